// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer: op and ALU
// encodings, FSM state encoding, iteration count and a magnitude helper.
package mdu_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Bundle between the EX stage / shared ALU and the multiply/divide sequencer.
interface mdu_if;
  import mdu_pkg::*;

  // Handshake: start is a single-cycle request, accepted only when busy is low;
  // busy stays high until the result is final, then done pulses for one cycle
  // while hi/lo hold the result. wr_hi/wr_lo are dropped while busy or on start.
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic [2:0]  alu_signal;
  logic [31:0] alu_result;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  start, op, src_a, src_b, wr_hi, wr_lo, wr_data, alu_result,
    output alu_dataA, alu_dataB, alu_signal, busy, done, hi, lo
  );

  modport master (
    output start, op, src_a, src_b, wr_hi, wr_lo, wr_data, alu_result,
    input  alu_dataA, alu_dataB, alu_signal, busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_step.sv
// One shift-add (multiply) or restoring-subtract (divide) iteration: ALU operand
// selection and next HI/LO, given the combinational ALU result.
module mdu_step
  import mdu_pkg::*;
(
  input  logic        i_is_div,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_operand,
  input  logic [31:0] i_alu_result,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [2:0]  o_alu_sig,
  output logic [31:0] o_next_hi,
  output logic [31:0] o_next_lo
);

  logic [31:0] w_rs;
  logic        w_q;
  logic        w_carry;

  // hi[31] shifted out means the partial remainder already exceeds any divisor.
  assign w_rs    = {i_hi[30:0], i_lo[31]};
  assign w_q     = i_hi[31] | (w_rs >= i_operand);
  assign w_carry = i_alu_result < i_hi;

  always_comb begin
    o_alu_a   = i_hi;
    o_alu_b   = '0;
    o_alu_sig = ALU_ADD;
    o_next_hi = i_hi;
    o_next_lo = i_lo;
    if (i_is_div) begin
      o_alu_a   = w_rs;
      o_alu_b   = i_operand;
      o_alu_sig = ALU_SUB;
      o_next_hi = w_q ? i_alu_result : w_rs;
      o_next_lo = {i_lo[30:0], w_q};
    end else begin
      o_alu_a   = i_hi;
      o_alu_b   = i_lo[0] ? i_operand : 32'd0;
      o_alu_sig = ALU_ADD;
      o_next_hi = {w_carry, i_alu_result[31:1]};
      o_next_lo = {i_alu_result[0], i_lo[31:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide controller driving the shared ALU for 32 steps.
// Define MDU_SIGNED_EN to run ops 10/11 signed (adds a FIX cycle); otherwise op[1] is ignored.
module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mdu_if.slave       bus,
  output mdu_state_t o_dbg_state
);

  mdu_state_t       r_state;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_operand;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_is_div;
  logic             w_div_zero;
  logic [31:0]      w_a_init;
  logic [31:0]      w_b_init;
  logic [31:0]      w_alu_a;
  logic [31:0]      w_alu_b;
  logic [2:0]       w_alu_sig;
  logic [31:0]      w_next_hi;
  logic [31:0]      w_next_lo;

  assign w_is_div   = bus.op[0];
  assign w_div_zero = w_is_div && (bus.src_b == 32'd0);
  assign w_accept   = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef MDU_SIGNED_EN
  logic        w_signed;
  logic        w_neg_res;
  logic        w_neg_rem;
  logic        r_signed;
  logic        r_neg_res;
  logic        r_neg_rem;
  logic [63:0] w_prod_neg;

  // Iterations run on magnitudes; the FIX cycle restores the signs.
  assign w_signed   = bus.op[1];
  assign w_a_init   = w_signed ? abs32(bus.src_a) : bus.src_a;
  assign w_b_init   = w_signed ? abs32(bus.src_b) : bus.src_b;
  assign w_neg_res  = w_signed & (bus.src_a[31] ^ bus.src_b[31]);
  assign w_neg_rem  = w_signed & bus.src_a[31];
  assign w_prod_neg = ~{r_hi, r_lo} + 64'd1;
`else
  logic w_unused_op1;
  assign w_unused_op1 = bus.op[1];
  assign w_a_init     = bus.src_a;
  assign w_b_init     = bus.src_b;
`endif

  mdu_step u_step (
    .i_is_div     (r_is_div),
    .i_hi         (r_hi),
    .i_lo         (r_lo),
    .i_operand    (r_operand),
    .i_alu_result (bus.alu_result),
    .o_alu_a      (w_alu_a),
    .o_alu_b      (w_alu_b),
    .o_alu_sig    (w_alu_sig),
    .o_next_hi    (w_next_hi),
    .o_next_lo    (w_next_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_operand <= '0;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MDU_SIGNED_EN
      r_signed  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
          if (w_accept) begin
            r_is_div  <= w_is_div;
            r_operand <= w_b_init;
            r_cnt     <= '0;
`ifdef MDU_SIGNED_EN
            r_signed  <= w_signed;
            r_neg_res <= w_neg_res;
            r_neg_rem <= w_neg_rem;
`endif
            if (w_div_zero) begin
              r_hi    <= bus.src_a;
              r_lo    <= 32'hFFFF_FFFF;
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_a_init;
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            if (bus.wr_hi) r_hi <= bus.wr_data;
            if (bus.wr_lo) r_lo <= bus.wr_data;
          end
        end
        ST_RUN: begin
          r_hi  <= w_next_hi;
          r_lo  <= w_next_lo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(ITER - 1)) begin
`ifdef MDU_SIGNED_EN
            if (r_signed) begin
              r_state <= ST_FIX;
            end else begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
`else
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef MDU_SIGNED_EN
        ST_FIX: begin
          if (!r_is_div) begin
            if (r_neg_res) {r_hi, r_lo} <= w_prod_neg;
          end else begin
            if (r_neg_res) r_lo <= ~r_lo + 32'd1;
            if (r_neg_rem) r_hi <= ~r_hi + 32'd1;
          end
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // The ALU is shared with the rest of EX, so it sees a neutral ADD 0+0 outside RUN.
  assign bus.alu_dataA  = (r_state == ST_RUN) ? w_alu_a   : 32'd0;
  assign bus.alu_dataB  = (r_state == ST_RUN) ? w_alu_b   : 32'd0;
  assign bus.alu_signal = (r_state == ST_RUN) ? w_alu_sig : ALU_ADD;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.hi         = r_hi;
  assign bus.lo         = r_lo;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed, table-driven bench for mdu_sequencer with a behavioural shared ALU.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic       clk;
  logic       rst;
  mdu_state_t dbg_state;
  int         n_checks;
  int         n_errors;

  mdu_if bus ();

  mdu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Shared ALU model: same-cycle result.
  assign bus.alu_result = (bus.alu_signal == ALU_SUB) ? (bus.alu_dataA - bus.alu_dataB)
                                                      : (bus.alu_dataA + bus.alu_dataB);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Launch one op from IDLE/DONE and follow it until done; returns the done cycle
  // (0 on timeout) and counts cycles with wrong busy/done or ALU opcode.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_bad, output int sig_bad);
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    lat      = 0;
    busy_bad = 0;
    sig_bad  = 0;
    for (int c = 1; c <= 100; c++) begin
      if (bus.done) begin
        lat = c;
        if (bus.busy) busy_bad++;
        break;
      end
      if (!bus.busy) busy_bad++;
      if (c <= ITER) begin
        if (bus.alu_signal !== (op[0] ? ALU_SUB : ALU_ADD)) sig_bad++;
      end else begin
        if (bus.alu_signal !== ALU_ADD) sig_bad++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    int busy_bad;
    int sig_bad;
    int done_seen;
    int c;

    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[1]  = '{2'b01, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 33};
    vecs[2]  = '{2'b01, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1};
    vecs[3]  = '{2'b00, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 33};
    vecs[4]  = '{2'b00, 32'd0,         32'd5,         32'h0,         32'h0,         33};
    vecs[5]  = '{2'b01, 32'd5,         32'd10,        32'h0000_0005, 32'h0,         33};
    vecs[6]  = '{2'b01, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 33};
    vecs[7]  = '{2'b01, 32'h8000_0000, 32'd3,         32'h0000_0002, 32'h2AAA_AAAA, 33};
    vecs[8]  = '{2'b00, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0,         33};
    vecs[9]  = '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
`ifdef MDU_SIGNED_EN
    vecs[10] = '{2'b10, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 34};
    vecs[11] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[12] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34};
    vecs[13] = '{2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0,         32'h0000_0006, 34};
`else
    vecs[10] = '{2'b10, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1, 33};
    vecs[11] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 33};
    vecs[12] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0007, 32'h0,         33};
    vecs[13] = '{2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0006, 33};
`endif

    // Clock/reset
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.src_a   = '0;
    bus.src_b   = '0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_hi", 64'(bus.hi), 64'h0);
    check("rst_lo", 64'(bus.lo), 64'h0);
    check("rst_busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
    check("rst_alu_ab", {bus.alu_dataA, bus.alu_dataB}, 64'h0);
    check("rst_alu_sig", 64'(bus.alu_signal), 64'(ALU_ADD));

    // Table vectors, issued back to back (each starts from the previous DONE cycle)
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_bad, sig_bad);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_hi", i), 64'(bus.hi), 64'(vecs[i].exp_hi));
      check($sformatf("v%0d_lo", i), 64'(bus.lo), 64'(vecs[i].exp_lo));
      check($sformatf("v%0d_busy", i), 64'(busy_bad), 64'h0);
      check($sformatf("v%0d_alu_sig", i), 64'(sig_bad), 64'h0);
    end

    // Done is a single pulse, then IDLE with a quiet ALU
    @(posedge clk);
    #1;
    check("done_pulse", 64'(bus.done), 64'h0);
    check("post_done_state", 64'(dbg_state), 64'(ST_IDLE));
    check("idle_alu_ab", {bus.alu_dataA, bus.alu_dataB}, 64'h0);

    // Start and wr_hi during RUN are both dropped
    bus.op    = 2'b01;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.op      = 2'b00;
    bus.src_a   = 32'd3;
    bus.src_b   = 32'd3;
    bus.start   = 1'b1;
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    lat = 0;
    for (c = 6; c <= 100; c++) begin
      if (bus.done) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("restart_ignored_lat", 64'(lat), 64'd33);
    check("restart_ignored_res", {bus.hi, bus.lo}, {32'h2, 32'hE});
    @(posedge clk);
    #1;

    // Reset at step 10 aborts with no done pulse
    bus.op    = 2'b00;
    bus.src_a = 32'd7;
    bus.src_b = 32'd9;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    check("abort_hilo", {bus.hi, bus.lo}, 64'h0);
    check("abort_busy", 64'(bus.busy), 64'h0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) done_seen++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 64'(done_seen), 64'h0);

    // MTHI / MTLO in IDLE
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'hAAAA_0000;
    @(posedge clk);
    #1;
    bus.wr_hi   = 1'b0;
    check("mthi", 64'(bus.hi), 64'hAAAA_0000);
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.wr_lo   = 1'b0;
    check("mtlo", {bus.hi, bus.lo}, {32'hAAAA_0000, 32'h1234_5678});

    // MTLO in the same cycle as start loses to start
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'hDEAD_BEEF;
    run_op(2'b00, 32'd3, 32'd4, lat, busy_bad, sig_bad);
    check("mtlo_start_lat", 64'(lat), 64'd33);
    check("mtlo_start_res", {bus.hi, bus.lo}, {32'h0, 32'hC});
    check("mtlo_start_busy", 64'(busy_bad), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
